// File: rtl/mma_pkg.sv
// Shared definitions for the MMA tile controller: bus-owner encoding and sequencer states.
package mma_pkg;

  localparam int unsigned ICB_SEL_W     = 3;
  localparam int unsigned NUM_ICB_PORTS = 5;

  localparam logic [ICB_SEL_W-1:0] ICB_SEL_IA     = 3'd0;
  localparam logic [ICB_SEL_W-1:0] ICB_SEL_WEIGHT = 3'd1;
  localparam logic [ICB_SEL_W-1:0] ICB_SEL_BIAS   = 3'd2;
  localparam logic [ICB_SEL_W-1:0] ICB_SEL_QUANT  = 3'd3;
  localparam logic [ICB_SEL_W-1:0] ICB_SEL_OA     = 3'd4;
  localparam logic [ICB_SEL_W-1:0] ICB_SEL_NONE   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_LOAD    = 3'd2,
    S_SEND    = 3'd3,
    S_COMPUTE = 3'd4,
    S_FLUSH   = 3'd5
  } ctrl_state_e;

  // One-hot grant vector for a bus owner; the "none" code maps to no grant.
  function automatic logic [NUM_ICB_PORTS-1:0] sel_to_gnt(input logic [ICB_SEL_W-1:0] sel);
    logic [NUM_ICB_PORTS-1:0] gnt;
    gnt = '0;
    if (sel != ICB_SEL_NONE) gnt = NUM_ICB_PORTS'(1) << sel;
    return gnt;
  endfunction

endpackage

// File: rtl/mma_icb_arbiter.sv
// Five-way fixed-priority ICB arbiter (OA > WEIGHT > IA > BIAS > QUANT) that holds a grant
// for as long as the owner keeps requesting.
module mma_icb_arbiter
  import mma_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_ICB_PORTS-1:0] req_i,
  output logic [NUM_ICB_PORTS-1:0] gnt_o,
  output logic [ICB_SEL_W-1:0]     sel_o
);

  logic [ICB_SEL_W-1:0]     sel_d, sel_q;
  logic [NUM_ICB_PORTS-1:0] gnt_d, gnt_q;
  logic                     hold_c;

  // The current owner keeps the bus while its request stays high; no preemption.
  assign hold_c = |(req_i & gnt_q);

  always_comb begin
    sel_d = ICB_SEL_NONE;
    if (hold_c)                     sel_d = sel_q;
    else if (req_i[ICB_SEL_OA])     sel_d = ICB_SEL_OA;
    else if (req_i[ICB_SEL_WEIGHT]) sel_d = ICB_SEL_WEIGHT;
    else if (req_i[ICB_SEL_IA])     sel_d = ICB_SEL_IA;
    else if (req_i[ICB_SEL_BIAS])   sel_d = ICB_SEL_BIAS;
    else if (req_i[ICB_SEL_QUANT])  sel_d = ICB_SEL_QUANT;
    gnt_d = sel_to_gnt(sel_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= ICB_SEL_NONE;
      gnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      gnt_q <= gnt_d;
    end
  end

  assign gnt_o = gnt_q;
  assign sel_o = sel_q;

endmodule

// File: rtl/mma_tile_controller.sv
// MMA top-level sequencer: config pulses, per-tile load/send/compute sequencing, tile
// counting and output flush, plus the shared ICB bus arbiter.
module mma_tile_controller
  import mma_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SIZE         = 16,
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned REG_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 calc_start,
  input  logic                 cfg_16bits_ia,
  output logic                 sa_ready,
  output logic [2:0]           icb_sel,
  output logic                 init_cfg_ia,
  output logic                 init_cfg_weight,
  output logic                 init_cfg_bias,
  output logic                 init_cfg_requant,
  output logic                 init_cfg_oa,
  output logic                 use_16bits,
  output logic [REG_WIDTH-1:0] tile_count,
  input  logic                 partial_sum_calc_over,
  input  logic                 load_ia_req,
  input  logic                 load_weight_req,
  input  logic                 load_bias_req,
  input  logic                 load_quant_req,
  input  logic                 write_oa_req,
  output logic                 load_ia_granted,
  output logic                 load_weight_granted,
  output logic                 load_bias_granted,
  output logic                 load_quant_granted,
  output logic                 write_oa_granted,
  output logic                 send_ia_trigger,
  output logic                 send_weight_trigger,
  input  logic                 ia_sending_done,
  input  logic                 weight_sending_done,
  input  logic                 ia_data_valid,
  input  logic                 weight_data_valid,
  input  logic                 bias_valid,
  input  logic                 quant_params_valid,
  input  logic                 fifo_full_flag,
  input  logic                 write_done,
  input  logic                 oa_calc_over
);

  // Datapath widths only matter to the loaders; an empty block keeps them referenced here.
  if (WEIGHT_WIDTH == 0 || DATA_WIDTH == 0 || SIZE == 0 || BUS_WIDTH == 0) begin : g_degenerate_cfg
  end

  ctrl_state_e          state_d, state_q;
  logic                 sa_ready_d, sa_ready_q;
  logic                 init_cfg_d, init_cfg_q;
  logic                 send_trig_d, send_trig_q;
  logic                 use_16bits_d, use_16bits_q;
  logic [REG_WIDTH-1:0] tile_count_d, tile_count_q;
  logic                 ia_done_d, ia_done_q;
  logic                 wt_done_d, wt_done_q;
  logic                 psum_pend_d, psum_pend_q;
  logic                 oa_seen_d, oa_seen_q;

  logic ia_done_c, wt_done_c, psum_c, oa_seen_c, tile_done_c, ops_ready_c;

  assign ia_done_c   = ia_done_q | ia_sending_done;
  assign wt_done_c   = wt_done_q | weight_sending_done;
  assign psum_c      = psum_pend_q | partial_sum_calc_over;
  assign oa_seen_c   = oa_seen_q | oa_calc_over;
  assign tile_done_c = (state_q == S_COMPUTE) && psum_c && ia_done_c && wt_done_c;
  assign ops_ready_c = ia_data_valid && weight_data_valid && bias_valid &&
                       quant_params_valid && !fifo_full_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (calc_start) state_d = S_INIT;
      S_INIT:    state_d = S_LOAD;
      S_LOAD:    if (ops_ready_c) state_d = S_SEND;
      S_SEND:    state_d = S_COMPUTE;
      S_COMPUTE: if (tile_done_c) state_d = oa_seen_c ? S_FLUSH : S_LOAD;
      S_FLUSH:   if (write_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pulses are decoded from the next state so they coincide with the state they belong to.
  always_comb begin
    sa_ready_d   = (state_d == S_IDLE);
    init_cfg_d   = (state_d == S_INIT);
    send_trig_d  = (state_d == S_SEND);
    use_16bits_d = use_16bits_q;
    tile_count_d = tile_count_q;
    ia_done_d    = ia_done_q;
    wt_done_d    = wt_done_q;
    psum_pend_d  = psum_pend_q;
    oa_seen_d    = oa_seen_q;
    unique case (state_q)
      S_IDLE: begin
        ia_done_d   = 1'b0;
        wt_done_d   = 1'b0;
        psum_pend_d = 1'b0;
        oa_seen_d   = 1'b0;
        if (calc_start) begin
          use_16bits_d = cfg_16bits_ia;
          tile_count_d = '0;
        end
      end
      S_SEND, S_COMPUTE: begin
        ia_done_d   = ia_done_c;
        wt_done_d   = wt_done_c;
        psum_pend_d = psum_c;
        oa_seen_d   = oa_seen_c;
        if (tile_done_c) begin
          tile_count_d = tile_count_q + REG_WIDTH'(1);
          ia_done_d    = 1'b0;
          wt_done_d    = 1'b0;
          psum_pend_d  = 1'b0;
        end
      end
      default: oa_seen_d = oa_seen_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_ready_q   <= 1'b1;
      init_cfg_q   <= 1'b0;
      send_trig_q  <= 1'b0;
      use_16bits_q <= 1'b0;
      tile_count_q <= '0;
      ia_done_q    <= 1'b0;
      wt_done_q    <= 1'b0;
      psum_pend_q  <= 1'b0;
      oa_seen_q    <= 1'b0;
    end else begin
      sa_ready_q   <= sa_ready_d;
      init_cfg_q   <= init_cfg_d;
      send_trig_q  <= send_trig_d;
      use_16bits_q <= use_16bits_d;
      tile_count_q <= tile_count_d;
      ia_done_q    <= ia_done_d;
      wt_done_q    <= wt_done_d;
      psum_pend_q  <= psum_pend_d;
      oa_seen_q    <= oa_seen_d;
    end
  end

  assign sa_ready            = sa_ready_q;
  assign init_cfg_ia         = init_cfg_q;
  assign init_cfg_weight     = init_cfg_q;
  assign init_cfg_bias       = init_cfg_q;
  assign init_cfg_requant    = init_cfg_q;
  assign init_cfg_oa         = init_cfg_q;
  assign send_ia_trigger     = send_trig_q;
  assign send_weight_trigger = send_trig_q;
  assign use_16bits          = use_16bits_q;
  assign tile_count          = tile_count_q;

  logic [NUM_ICB_PORTS-1:0] icb_req, icb_gnt;

  assign icb_req = {write_oa_req, load_quant_req, load_bias_req, load_weight_req, load_ia_req};

  mma_icb_arbiter u_arbiter (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (icb_req),
    .gnt_o (icb_gnt),
    .sel_o (icb_sel)
  );

  assign load_ia_granted     = icb_gnt[ICB_SEL_IA];
  assign load_weight_granted = icb_gnt[ICB_SEL_WEIGHT];
  assign load_bias_granted   = icb_gnt[ICB_SEL_BIAS];
  assign load_quant_granted  = icb_gnt[ICB_SEL_QUANT];
  assign write_oa_granted    = icb_gnt[ICB_SEL_OA];

endmodule

// File: tb/tb_mma_tile_controller.sv
// Directed bench for mma_tile_controller: run sequencing, back-pressure, arbitration and
// mid-run reset, with expected tile counts and bus owners queued as stimulus is driven.
module tb_mma_tile_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        calc_start, cfg_16bits_ia;
  logic        sa_ready;
  logic [2:0]  icb_sel;
  logic        init_cfg_ia, init_cfg_weight, init_cfg_bias, init_cfg_requant, init_cfg_oa;
  logic        use_16bits;
  logic [31:0] tile_count;
  logic        partial_sum_calc_over;
  logic        load_ia_req, load_weight_req, load_bias_req, load_quant_req, write_oa_req;
  logic        load_ia_granted, load_weight_granted, load_bias_granted, load_quant_granted;
  logic        write_oa_granted;
  logic        send_ia_trigger, send_weight_trigger;
  logic        ia_sending_done, weight_sending_done;
  logic        ia_data_valid, weight_data_valid, bias_valid, quant_params_valid;
  logic        fifo_full_flag, write_done, oa_calc_over;

  logic [4:0]  gv, iv;
  logic [1:0]  tv;
  assign gv = {write_oa_granted, load_quant_granted, load_bias_granted,
               load_weight_granted, load_ia_granted};
  assign iv = {init_cfg_ia, init_cfg_weight, init_cfg_bias, init_cfg_requant, init_cfg_oa};
  assign tv = {send_ia_trigger, send_weight_trigger};

  int n_checks = 0;
  int n_fail   = 0;
  int trig_cnt = 0;
  logic [31:0] tile_sb[$];
  logic [2:0]  arb_sb[$];

  always #5 clk = ~clk;

  mma_tile_controller dut (
    .clk(clk), .rst_n(rst_n), .calc_start(calc_start), .cfg_16bits_ia(cfg_16bits_ia),
    .sa_ready(sa_ready), .icb_sel(icb_sel),
    .init_cfg_ia(init_cfg_ia), .init_cfg_weight(init_cfg_weight), .init_cfg_bias(init_cfg_bias),
    .init_cfg_requant(init_cfg_requant), .init_cfg_oa(init_cfg_oa),
    .use_16bits(use_16bits), .tile_count(tile_count),
    .partial_sum_calc_over(partial_sum_calc_over),
    .load_ia_req(load_ia_req), .load_weight_req(load_weight_req), .load_bias_req(load_bias_req),
    .load_quant_req(load_quant_req), .write_oa_req(write_oa_req),
    .load_ia_granted(load_ia_granted), .load_weight_granted(load_weight_granted),
    .load_bias_granted(load_bias_granted), .load_quant_granted(load_quant_granted),
    .write_oa_granted(write_oa_granted),
    .send_ia_trigger(send_ia_trigger), .send_weight_trigger(send_weight_trigger),
    .ia_sending_done(ia_sending_done), .weight_sending_done(weight_sending_done),
    .ia_data_valid(ia_data_valid), .weight_data_valid(weight_data_valid),
    .bias_valid(bias_valid), .quant_params_valid(quant_params_valid),
    .fifo_full_flag(fifo_full_flag), .write_done(write_done), .oa_calc_over(oa_calc_over)
  );

  always @(negedge clk) if (send_ia_trigger) trig_cnt <= trig_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_gnt(input logic [2:0] sel);
    case (sel)
      3'd0:    return 5'b00001;
      3'd1:    return 5'b00010;
      3'd2:    return 5'b00100;
      3'd3:    return 5'b01000;
      3'd4:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // Drive a request set {oa,quant,bias,weight,ia}, then check owner and grants next cycle.
  task automatic arb_step(input logic [4:0] req, input logic [2:0] exp_sel, input string tag);
    logic [2:0] e;
    {write_oa_req, load_quant_req, load_bias_req, load_weight_req, load_ia_req} = req;
    arb_sb.push_back(exp_sel);
    step();
    e = arb_sb.pop_front();
    chk({tag, " sel"}, 32'(icb_sel), 32'(e));
    chk({tag, " gnt"}, 32'(gv), 32'(exp_gnt(e)));
  endtask

  task automatic wait_trig(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (send_ia_trigger) break;
      step();
    end
    chk(tag, 32'(tv), 32'd3);
  endtask

  task automatic check_tile(input string tag);
    logic [31:0] e;
    e = tile_sb.pop_front();
    chk(tag, tile_count, e);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; calc_start = 1'b0; cfg_16bits_ia = 1'b0; partial_sum_calc_over = 1'b0;
    {write_oa_req, load_quant_req, load_bias_req, load_weight_req, load_ia_req} = 5'b0;
    ia_sending_done = 1'b0; weight_sending_done = 1'b0;
    {ia_data_valid, weight_data_valid, bias_valid, quant_params_valid} = 4'b0;
    fifo_full_flag = 1'b0; write_done = 1'b0; oa_calc_over = 1'b0;
    repeat (2) step();
    chk("rst sa_ready", 32'(sa_ready), 32'd1);
    chk("rst icb_sel", 32'(icb_sel), 32'd7);
    chk("rst tile_count", tile_count, 32'd0);
    chk("rst grants", 32'(gv), 32'd0);
    chk("rst init", 32'(iv), 32'd0);
    chk("rst trig", 32'(tv), 32'd0);
    rst_n = 1'b1;
    step();

    // 8-bit single tile
    cfg_16bits_ia = 1'b0; calc_start = 1'b1;
    step();
    calc_start = 1'b0;
    chk("t1 init pulse", 32'(iv), 32'h1f);
    chk("t1 sa_ready low", 32'(sa_ready), 32'd0);
    chk("t1 use_16bits", 32'(use_16bits), 32'd0);
    chk("t1 tile clear", tile_count, 32'd0);
    {ia_data_valid, weight_data_valid, bias_valid, quant_params_valid} = 4'hf;
    step();
    chk("t1 init one cycle", 32'(iv), 32'd0);
    step();
    chk("t1 trigger", 32'(tv), 32'd3);
    step();
    chk("t1 trigger one cycle", 32'(tv), 32'd0);
    ia_sending_done = 1'b1; weight_sending_done = 1'b1;
    step();
    ia_sending_done = 1'b0; weight_sending_done = 1'b0;
    partial_sum_calc_over = 1'b1; oa_calc_over = 1'b1;
    tile_sb.push_back(32'd1);
    step();
    partial_sum_calc_over = 1'b0; oa_calc_over = 1'b0;
    check_tile("t1 tile_count");
    step();
    chk("t1 flush not ready", 32'(sa_ready), 32'd0);
    chk("t1 no retrigger", 32'(tv), 32'd0);
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    chk("t1 sa_ready back", 32'(sa_ready), 32'd1);

    // 16-bit three tiles, second tile's partial sum arrives before the sending-done pulses
    base = trig_cnt;
    cfg_16bits_ia = 1'b1; calc_start = 1'b1;
    step();
    calc_start = 1'b0; cfg_16bits_ia = 1'b0;
    chk("t2 use_16bits", 32'(use_16bits), 32'd1);
    chk("t2 tile clear", tile_count, 32'd0);
    for (int t = 0; t < 3; t++) begin
      wait_trig("t2 trigger");
      step();
      if (t == 1) begin
        partial_sum_calc_over = 1'b1;
        step();
        partial_sum_calc_over = 1'b0;
        chk("t2 early psum held", tile_count, 32'd1);
        ia_sending_done = 1'b1; weight_sending_done = 1'b1;
        tile_sb.push_back(32'd2);
        step();
        ia_sending_done = 1'b0; weight_sending_done = 1'b0;
      end else begin
        ia_sending_done = 1'b1; weight_sending_done = 1'b1;
        step();
        ia_sending_done = 1'b0; weight_sending_done = 1'b0;
        partial_sum_calc_over = 1'b1; oa_calc_over = (t == 2);
        tile_sb.push_back(32'(t + 1));
        step();
        partial_sum_calc_over = 1'b0; oa_calc_over = 1'b0;
      end
      check_tile("t2 tile_count");
    end
    chk("t2 three triggers", 32'(trig_cnt - base), 32'd3);
    chk("t2 use_16bits held", 32'(use_16bits), 32'd1);
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    chk("t2 sa_ready back", 32'(sa_ready), 32'd1);

    // Arbitration
    arb_step(5'b00001, 3'd0, "a ia alone");
    arb_step(5'b00000, 3'd7, "a ia drop");
    arb_step(5'b10101, 3'd4, "a oa first");
    arb_step(5'b10101, 3'd4, "a oa hold");
    arb_step(5'b00101, 3'd0, "a ia after oa");
    arb_step(5'b00111, 3'd0, "a no preempt");
    arb_step(5'b00110, 3'd1, "a weight");
    arb_step(5'b01100, 3'd2, "a bias over quant");
    arb_step(5'b01000, 3'd3, "a quant");
    arb_step(5'b10000, 3'd4, "a handover no gap");
    arb_step(5'b00000, 3'd7, "a idle");
    arb_step(5'b10011, 3'd4, "a oa over weight");
    arb_step(5'b00011, 3'd1, "a weight over ia");
    arb_step(5'b00000, 3'd7, "a release");

    // Back-pressure, then reset in COMPUTE with a grant active
    fifo_full_flag = 1'b1; calc_start = 1'b1;
    step();
    calc_start = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp no trigger", 32'(tv), 32'd0);
    end
    fifo_full_flag = 1'b0;
    step();
    chk("bp release trigger", 32'(tv), 32'd3);
    step();
    load_ia_req = 1'b1;
    ia_sending_done = 1'b1; weight_sending_done = 1'b1;
    step();
    ia_sending_done = 1'b0; weight_sending_done = 1'b0;
    partial_sum_calc_over = 1'b1;
    tile_sb.push_back(32'd1);
    step();
    partial_sum_calc_over = 1'b0;
    check_tile("bp tile_count");
    step();
    step();
    chk("rm grant before reset", 32'(gv), 32'd1);
    chk("rm busy before reset", 32'(sa_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm sa_ready", 32'(sa_ready), 32'd1);
    chk("rm grants", 32'(gv), 32'd0);
    chk("rm icb_sel", 32'(icb_sel), 32'd7);
    chk("rm tile_count", tile_count, 32'd0);
    load_ia_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rm idle after reset", 32'(sa_ready), 32'd1);
    chk("rm no trigger after reset", 32'(tv), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mma_tile_controller.md
Name: mma_tile_controller

Overview:
- Top-level sequencer of the matrix-multiply accelerator (MMA).
- Accepts a calculation start and issues one-cycle configuration pulses to the loaders (IA, weight, bias, requant) and the OA writer.
- Sequences tile loading, systolic-array send triggers and partial-sum completion, and counts tiles.
- Arbitrates the single shared ICB memory bus among the five loaders/writer.

Parameters:
- WEIGHT_WIDTH, 8, weight element width (informational, passed through).
- DATA_WIDTH, 16, accumulator/data width (informational).
- SIZE, 16, systolic array dimension (informational).
- BUS_WIDTH, 32, ICB data width (informational).
- REG_WIDTH, 32, width of tile_count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- calc_start  in  1  start pulse, accepted only when sa_ready=1.
- cfg_16bits_ia  in  1  IA precision for this run: 1=16-bit, 0=8-bit.
- sa_ready  out  1  controller idle, can accept calc_start.
- icb_sel  out  3  bus owner: 0=IA, 1=WEIGHT, 2=BIAS, 3=QUANT, 4=OA, 7=none.
- init_cfg_ia, init_cfg_weight, init_cfg_bias, init_cfg_requant, init_cfg_oa  out  1 each  one-cycle config pulses.
- use_16bits  out  1  latched cfg_16bits_ia.
- tile_count  out  REG_WIDTH  tiles completed in the current run.
- partial_sum_calc_over  in  1  current tile's partial sum finished (pulse).
- load_ia_req / load_weight_req / load_bias_req / load_quant_req / write_oa_req  in  1  bus requests (level).
- load_ia_granted / load_weight_granted / load_bias_granted / load_quant_granted / write_oa_granted  out  1  bus grants.
- send_ia_trigger, send_weight_trigger  out  1  pulses starting array feed.
- ia_sending_done, weight_sending_done  in  1  feed finished (pulse).
- ia_data_valid, weight_data_valid, bias_valid, quant_params_valid  in  1  operand buffers loaded (level).
- fifo_full_flag  in  1  output FIFO full; blocks send triggers.
- write_done  in  1  OA writer drained all output (pulse).
- oa_calc_over  in  1  final tile of the run computed (pulse).

Behaviour:
- Reset values: all outputs 0, except sa_ready=1 and icb_sel=7.
- FSM states: IDLE, INIT, LOAD, SEND, COMPUTE, FLUSH.
- IDLE:
  - sa_ready=1.
  - On calc_start, latch use_16bits<=cfg_16bits_ia, clear tile_count, and go to INIT.
- INIT: all five init_cfg_* high for exactly one cycle, then go to LOAD.
- LOAD: wait until ia_data_valid & weight_data_valid & bias_valid & quant_params_valid & !fifo_full_flag, then go to SEND.
- SEND: send_ia_trigger and send_weight_trigger high for exactly one cycle, then go to COMPUTE.
- COMPUTE:
  - Latch ia_sending_done and weight_sending_done into sticky flags.
  - On partial_sum_calc_over with both flags set: tile_count+1, clear flags.
  - Then go to FLUSH if an oa_calc_over has been seen (sticky, cleared in IDLE), else back to LOAD.
  - partial_sum_calc_over before both sending-done flags are set is held pending until they are.
- FLUSH: wait for write_done, then go to IDLE. sa_ready rises the cycle after write_done.
- oa_calc_over is latched in any non-IDLE state and is ignored in IDLE.
- calc_start outside IDLE is ignored.
- Latency: calc_start to init pulses is 1 cycle. Valids met to triggers is 1 cycle.
- tile_count wraps modulo 2^REG_WIDTH.
- Arbiter (independent of FSM, active in all states):
  - Fixed priority OA > WEIGHT > IA > BIAS > QUANT.
  - When the bus is free, the highest-priority requester is granted, registered: grant appears the cycle after the request.
  - A grant is held while its req stays high, with no preemption even if a higher-priority req arrives.
  - When the owner drops req, its grant drops the next cycle. A new grant can issue in that same cycle (no idle gap required).
  - At most one grant is high at a time. icb_sel matches the granted owner, or 7 when none.
- Reset asserted mid-run: immediate return to IDLE, all grants dropped, tile_count=0.

Decomposition:
- Shared package mma_pkg holds:
  - icb_sel encoding constants (ICB_SEL_IA..ICB_SEL_OA, ICB_SEL_NONE).
  - FSM state enum.
- One sub-module: mma_icb_arbiter (5-way fixed-priority, grant-hold arbiter producing grants and icb_sel).

Test Plan:
- 8-bit single tile:
  - Stimulus: cfg_16bits_ia=0, calc_start; assert all four valids; pulse both sending_done; pulse partial_sum_calc_over with oa_calc_over; pulse write_done.
  - Required: init_cfg_* high 1 cycle, use_16bits=0, triggers 1 cycle, tile_count=1, sa_ready returns to 1.
- 16-bit three tiles:
  - Stimulus: cfg_16bits_ia=1; three LOAD/SEND/COMPUTE loops, with oa_calc_over only on the third.
  - Required: use_16bits=1, tile_count=3, three trigger pulses.
- Back-pressure: fifo_full_flag=1 with all valids high -> no trigger; release it -> triggers next cycle.
- Simple arbitration:
  - Stimulus: load_ia_req alone.
  - Required: load_ia_granted next cycle, icb_sel=0; drop req -> icb_sel=7.
- Complex arbitration:
  - Stimulus: IA, bias and OA requests in the same cycle.
  - Required: OA is granted first (icb_sel=4); on its release WEIGHT if requesting, else IA, then BIAS. No grant overlap; an active grant is not preempted.
- Reset mid-run: rst_n low in COMPUTE -> sa_ready=1, grants 0, tile_count=0 immediately.
